// File: rtl/matrix_data_mem_if.sv
// Bus bundle for matrix_data_mem; parity pins exist only with MATRIX_DATA_MEM_PARITY_EN.
// Handshake: wr_en/rd_en are taken at a rising edge only while busy is low (no back-pressure);
// rd_valid, rd_data and addr_err answer exactly one cycle after the accepted request.
interface matrix_data_mem_if #(
   parameter int DW = 32,
   parameter int AW = 7
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          busy;
   logic          addr_err;
   logic          state_dbg;   // 0 = INIT, 1 = READY
`ifdef MATRIX_DATA_MEM_PARITY_EN
   logic          perr_inj;
   logic          rd_perr;

   modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr, perr_inj,
                   input  rd_data, rd_valid, busy, addr_err, state_dbg, rd_perr);
   modport slave  (input  wr_en, wr_addr, wr_data, rd_en, rd_addr, perr_inj,
                   output rd_data, rd_valid, busy, addr_err, state_dbg, rd_perr);
`else
   modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr,
                   input  rd_data, rd_valid, busy, addr_err, state_dbg);
   modport slave  (input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
                   output rd_data, rd_valid, busy, addr_err, state_dbg);
`endif
endinterface

// File: rtl/matrix_data_mem.sv
// Word memory with a self-clearing init engine, registered 1-cycle reads and write-first bypass.
// Optional macro MATRIX_DATA_MEM_PARITY_EN adds a stored even-parity bit per word.
module matrix_data_mem #(
   parameter int            DW       = 32,
   parameter int            DEPTH    = 100,
   parameter int            AW       = 7,
   parameter logic [DW-1:0] INIT_VAL = DW'(1)
) (
   input  logic               clk,
   input  logic               rst,
   matrix_data_mem_if.slave   bus
);

`ifdef MATRIX_DATA_MEM_PARITY_EN
   localparam int MW = DW + 1;   // {parity, data}
`else
   localparam int MW = DW;
`endif
   localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

   state_t        state, state_next;
   logic [AW-1:0] ptr, ptr_next;
   logic [MW-1:0] mem [DEPTH];

   logic          ready, wr_in, rd_in, wr_ok, bypass;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [MW-1:0] mem_wdata, user_word, init_word, rd_word;

   logic [DW-1:0] rd_data_q;
   logic          rd_valid_q, busy_q, addr_err_q;

   assign ready = (state == READY);
   assign wr_in = ({1'b0, bus.wr_addr} < DEPTH_W);
   assign rd_in = ({1'b0, bus.rd_addr} < DEPTH_W);
   assign wr_ok = ready && bus.wr_en && wr_in;
   assign bypass = wr_ok && (bus.wr_addr == bus.rd_addr);

`ifdef MATRIX_DATA_MEM_PARITY_EN
   // perr_inj flips the stored parity so a later read reports a failure
   assign user_word = {(^bus.wr_data) ^ bus.perr_inj, bus.wr_data};
   assign init_word = {^INIT_VAL, INIT_VAL};
`else
   assign user_word = bus.wr_data;
   assign init_word = INIT_VAL;
`endif

   assign rd_word = bypass ? user_word : mem[bus.rd_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   // The init engine owns the single write port while in INIT; user writes only in READY
   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      mem_we     = 1'b0;
      mem_waddr  = bus.wr_addr;
      mem_wdata  = user_word;
      case (state)
         INIT: begin
            mem_we    = 1'b1;
            mem_waddr = ptr;
            mem_wdata = init_word;
            ptr_next  = ptr + AW'(1);
            if (ptr == LAST_ADDR) state_next = READY;
         end
         READY: mem_we = wr_ok;
         default: state_next = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q     <= 1'b1;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         addr_err_q <= 1'b0;
      end else begin
         busy_q     <= (state_next == INIT);
         rd_valid_q <= ready && bus.rd_en;
         addr_err_q <= ready && ((bus.wr_en && !wr_in) || (bus.rd_en && !rd_in));
         if (ready && bus.rd_en) rd_data_q <= rd_in ? rd_word[DW-1:0] : '0;
      end
   end

`ifdef MATRIX_DATA_MEM_PARITY_EN
   logic rd_perr_q;

   always_ff @(posedge clk) begin
      if (rst) rd_perr_q <= 1'b0;
      else     rd_perr_q <= ready && bus.rd_en && rd_in && (^rd_word);
   end

   assign bus.rd_perr = rd_perr_q;
`endif

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.busy      = busy_q;
   assign bus.addr_err  = addr_err_q;
   assign bus.state_dbg = state;

endmodule

// File: doc/matrix_data_mem.md
MATRIX_DATA_MEM -- requirements
Module: matrix_data_mem

Interface
REQ-001 Parameter DW, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 100, number of words.
REQ-003 Parameter AW, default 7, address width; DEPTH SHALL be <= 2**AW.
REQ-004 Parameter INIT_VAL, default 1, value written to every word by the init engine.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_addr  input  AW  write address.
REQ-009 wr_data  input  DW  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_addr  input  AW  read address.
REQ-012 rd_data  output  DW  registered read data.
REQ-013 rd_valid  output  1  one-cycle pulse; rd_data is valid this cycle.
REQ-014 busy  output  1  high during reset and init; all accesses ignored.
REQ-015 addr_err  output  1  one-cycle pulse on an accepted access with address >= DEPTH.

Function
REQ-016 FSM states: INIT and READY; rst forces INIT with fill pointer 0.
REQ-017 INIT, rst low: each cycle write INIT_VAL to word[ptr], then ptr+1; the write to DEPTH-1 moves the FSM to READY. busy falls exactly DEPTH cycles after the first edge with rst low.
REQ-018 busy = 1 in INIT, 0 in READY, registered.
REQ-019 While busy: wr_en is dropped, rd_en gives no rd_valid, and addr_err stays 0.
REQ-020 READY, wr_en, wr_addr < DEPTH: word[wr_addr] <= wr_data at the edge.
REQ-021 READY, rd_en, rd_addr < DEPTH: rd_data = word[rd_addr] and rd_valid = 1 one cycle after the request; latency is fixed at 1.
REQ-022 Read and write to the same address in the same cycle: rd_data returns the new wr_data (write-first bypass).
REQ-023 Write and read to different addresses in the same cycle: both complete independently.
REQ-024 Out-of-range write (wr_addr >= DEPTH): no storage change; addr_err pulses the next cycle.
REQ-025 Out-of-range read: rd_data = 0 and rd_valid = 1 the next cycle; addr_err pulses in the same cycle.
REQ-026 rd_en low: rd_valid = 0 and rd_data holds its last value.
REQ-027 Back-to-back reads every cycle: one rd_valid per request, no bubbles.

Reset
REQ-028 During rst: busy = 1, rd_valid = 0, rd_data = 0, addr_err = 0, FSM = INIT, ptr = 0.
REQ-029 rst asserted mid-INIT or mid-READY: init restarts from word 0 on release; all prior contents are overwritten with INIT_VAL.
REQ-030 Memory contents change only through the init engine or accepted writes.

Configuration
REQ-031 Macro MATRIX_DATA_MEM_PARITY_EN defined: each word stores an extra even-parity bit computed on write and by init. Extra ports: perr_inj (input, 1; inverts the stored parity bit of the current accepted write) and rd_perr (output, 1; asserted alongside rd_valid when the read word fails its parity check, forced 0 on out-of-range reads, reset 0).
REQ-032 Macro undefined: no parity storage, and neither perr_inj nor rd_perr exists; all other behaviour is identical.

Verification
REQ-033 Release rst; count cycles to busy low = 100; read addresses 0, 50, 99 -> rd_data = 1 each, rd_valid one cycle after each rd_en.
REQ-034 Write 0xDEADBEEF to addr 5, then read addr 5 next cycle -> 0xDEADBEEF; same-cycle write 0x12345678 and read of addr 7 -> rd_data 0x12345678.
REQ-035 Write addr 100 and read addr 120 -> addr_err pulses, rd_data = 0 with rd_valid = 1, and a readback of addr 0-99 is unchanged.
REQ-036 Assert rst at init cycle 40 after earlier writing 0xAA to addr 3 -> busy stays high for 100 cycles after release, and addr 3 reads 1.
REQ-037 Pulse wr_en and rd_en during busy -> no rd_valid, no addr_err, and the written address reads INIT_VAL after init.
REQ-038 With MATRIX_DATA_MEM_PARITY_EN: write addr 9 with perr_inj = 1, then read -> rd_perr = 1; read addr 10 -> rd_perr = 0.
